fp_round_pack_stage: RTL and testbench

- Pipeline stage 5 of the Add_Sub floating-point datapath; sits directly downstream of normalization stage 4.
- Consumes the normalized mantissa, round decision and first-updated exponent. Applies the rounding increment, renormalizes on rounding carry, performs the second exponent update, detects overflow and zero, and packs the IEEE-754 result.
- Registered output with a valid/ready handshake so the adder pipeline can stall under back-pressure.

---
 rtl/fp_round_pack_stage.sv | 124 ++++++++++++
 tb/tb_fp_round_pack_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pack_stage.sv
// Add_Sub stage 5: rounding increment, carry renormalization, second exponent update, IEEE-754 pack.
// Optional STICKY_FLAGS_EN adds FlagClear/StickyOverflow for an overflow flag held across transfers.
module fp_round_pack_stage #(
    parameter int DataSize     = 32,
    parameter int FractionSize = 23,
    parameter int MantissaSize = FractionSize + 1,
    parameter int ExponentSize = 8
) (
    input  logic                    Clk,
    input  logic                    ResetN,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic                    Sign,
    input  logic [MantissaSize-1:0] TobeRounded,
    input  logic                    Round,
    input  logic [ExponentSize-1:0] ExponentAdderResult1,
    input  logic                    EffExponentAdderCarry1,
    input  logic                    SpecialIn,
    input  logic [DataSize-1:0]     SpecialResult,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [DataSize-1:0]     Result,
    output logic                    Overflow,
    output logic                    Zero
`ifdef STICKY_FLAGS_EN
    ,
    input  logic                    FlagClear,
    output logic                    StickyOverflow
`endif
);

    logic                    out_valid_q, out_valid_d;
    logic [DataSize-1:0]     result_q, result_d;
    logic                    overflow_q, overflow_d;
    logic                    zero_q, zero_d;

    logic                    accept;
    logic [MantissaSize:0]   rnd_sum;
    logic [MantissaSize-1:0] mant;
    logic                    exp_inc;
    logic [ExponentSize:0]   exp2;
    logic                    ovf;
    logic [DataSize-1:0]     result_nxt;
    logic                    overflow_nxt, zero_nxt;

    assign InReady = ~out_valid_q | OutReady;
    assign accept  = InValid & InReady;

    always_comb begin
        rnd_sum = {1'b0, TobeRounded} + {{MantissaSize{1'b0}}, Round};
        exp_inc = rnd_sum[MantissaSize];
        // A rounding carry only happens from all-ones, so the shifted value is exactly 1.000..0.
        mant    = exp_inc ? rnd_sum[MantissaSize:1] : rnd_sum[MantissaSize-1:0];
        exp2    = {1'b0, ExponentAdderResult1} + {{ExponentSize{1'b0}}, exp_inc};
        ovf     = EffExponentAdderCarry1 | exp2[ExponentSize] | (&exp2[ExponentSize-1:0]);

        result_nxt   = {Sign, exp2[ExponentSize-1:0], mant[FractionSize-1:0]};
        overflow_nxt = 1'b0;
        zero_nxt     = 1'b0;
        if (SpecialIn) begin
            result_nxt = SpecialResult;
        end else if ((TobeRounded == '0) && !Round) begin
            result_nxt = '0;
            zero_nxt   = 1'b1;
        end else if (ovf) begin
            result_nxt   = {Sign, {ExponentSize{1'b1}}, {FractionSize{1'b0}}};
            overflow_nxt = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = result_nxt;
            overflow_d  = overflow_nxt;
            zero_d      = zero_nxt;
        end else if (OutReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign OutValid = out_valid_q;
    assign Result   = result_q;
    assign Overflow = overflow_q;
    assign Zero     = zero_q;

`ifdef STICKY_FLAGS_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (FlagClear)
            sticky_d = 1'b0;
        else if (out_valid_q && OutReady && overflow_q)
            sticky_d = 1'b1;
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) sticky_q <= 1'b0;
        else         sticky_q <= sticky_d;
    end

    assign StickyOverflow = sticky_q;
`endif

endmodule

// File: tb/tb_fp_round_pack_stage.sv
// Directed bench for fp_round_pack_stage: vector table plus back-pressure, streaming and reset sequences.
module tb_fp_round_pack_stage;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic        Sign = 1'b0;
    logic [23:0] TobeRounded = '0;
    logic        Round = 1'b0;
    logic [7:0]  ExponentAdderResult1 = '0;
    logic        EffExponentAdderCarry1 = 1'b0;
    logic        SpecialIn = 1'b0;
    logic [31:0] SpecialResult = '0;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [31:0] Result;
    logic        Overflow;
    logic        Zero;
`ifdef STICKY_FLAGS_EN
    logic        FlagClear = 1'b0;
    logic        StickyOverflow;
`endif

    fp_round_pack_stage dut (
        .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .Sign(Sign), .TobeRounded(TobeRounded), .Round(Round),
        .ExponentAdderResult1(ExponentAdderResult1),
        .EffExponentAdderCarry1(EffExponentAdderCarry1),
        .SpecialIn(SpecialIn), .SpecialResult(SpecialResult),
        .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
        .Overflow(Overflow), .Zero(Zero)
`ifdef STICKY_FLAGS_EN
        , .FlagClear(FlagClear), .StickyOverflow(StickyOverflow)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic        sign;
        logic [23:0] tbr;
        logic        rnd;
        logic [7:0]  exp1;
        logic        carry1;
        logic        special;
        logic [31:0] sres;
        logic [31:0] exp_result;
        logic        exp_ovf;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Sign                   = v.sign;
        TobeRounded            = v.tbr;
        Round                  = v.rnd;
        ExponentAdderResult1   = v.exp1;
        EffExponentAdderCarry1 = v.carry1;
        SpecialIn              = v.special;
        SpecialResult          = v.sres;
        InValid                = 1'b1;
    endtask

    task automatic check_out(input vec_t v);
        check({v.name, " valid"},    {31'b0, OutValid}, 32'd1);
        check({v.name, " result"},   Result, v.exp_result);
        check({v.name, " overflow"}, {31'b0, Overflow}, {31'b0, v.exp_ovf});
        check({v.name, " zero"},     {31'b0, Zero},     {31'b0, v.exp_zero});
    endtask

    initial begin
        vec_t a, b, s;
        vecs.push_back('{"plain_neg",     1, 24'hC00000, 0, 8'h7F, 0, 0, 32'h0, 32'hBFC00000, 0, 0});
        vecs.push_back('{"round_carry",   0, 24'hFFFFFF, 1, 8'h7F, 0, 0, 32'h0, 32'h40000000, 0, 0});
        vecs.push_back('{"carry_to_ovf",  0, 24'hFFFFFF, 1, 8'hFE, 0, 0, 32'h0, 32'h7F800000, 1, 0});
        vecs.push_back('{"carry1_ovf",    0, 24'h800000, 0, 8'h10, 1, 0, 32'h0, 32'h7F800000, 1, 0});
        vecs.push_back('{"zero_neg",      1, 24'h000000, 0, 8'h55, 0, 0, 32'h0, 32'h00000000, 0, 1});
        vecs.push_back('{"special_nan",   0, 24'h123456, 1, 8'h7F, 0, 1, 32'h7FC00000, 32'h7FC00000, 0, 0});
        vecs.push_back('{"round_nocarry", 0, 24'h800000, 1, 8'h7F, 0, 0, 32'h0, 32'h3F800001, 0, 0});
        vecs.push_back('{"exp_ff_ovf",    1, 24'h800000, 0, 8'hFF, 0, 0, 32'h0, 32'hFF800000, 1, 0});
        vecs.push_back('{"zero_mant_rnd", 0, 24'h000000, 1, 8'h01, 0, 0, 32'h0, 32'h00800001, 0, 0});
        vecs.push_back('{"round_max",     1, 24'hFFFFFE, 1, 8'h80, 0, 0, 32'h0, 32'hC07FFFFF, 0, 0});
        vecs.push_back('{"special_prio",  1, 24'h000000, 0, 8'hFF, 1, 1, 32'h12345678, 32'h12345678, 0, 0});
        vecs.push_back('{"zero_prio",     0, 24'h000000, 0, 8'hFF, 1, 0, 32'h0, 32'h00000000, 0, 1});
        vecs.push_back('{"carry_to_fe",   0, 24'hFFFFFF, 1, 8'hFD, 0, 0, 32'h0, 32'h7F000000, 0, 0});

        // Reset state
        #1;
        check("rst valid",    {31'b0, OutValid}, 32'd0);
        check("rst result",   Result, 32'd0);
        check("rst overflow", {31'b0, Overflow}, 32'd0);
        check("rst zero",     {31'b0, Zero}, 32'd0);
        check("rst inready",  {31'b0, InReady}, 32'd1);
        @(negedge Clk);
        ResetN = 1'b1;
        @(posedge Clk); #1;

        // Table vectors, one accept per item, single-cycle latency
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge Clk); #1;
            InValid = 1'b0;
            check_out(vecs[i]);
        end
        @(posedge Clk); #1;
        check("drain valid", {31'b0, OutValid}, 32'd0);

        // Back-pressure: A held while B waits
        a = vecs[0];
        b = vecs[1];
        OutReady = 1'b0;
        drive(a);
        @(posedge Clk); #1;
        check_out(a);
        drive(b);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp inready", {31'b0, InReady}, 32'd0);
            check("bp hold result", Result, a.exp_result);
            check("bp hold valid", {31'b0, OutValid}, 32'd1);
            @(posedge Clk); #1;
        end
        OutReady = 1'b1;
        #1;
        check("bp release inready", {31'b0, InReady}, 32'd1);
        check("bp release result", Result, a.exp_result);
        @(posedge Clk); #1;
        InValid = 1'b0;
        check_out(b);
        @(posedge Clk); #1;
        check("bp drained", {31'b0, OutValid}, 32'd0);

        // Back-to-back stream of 8 items
        for (int i = 0; i < 8; i++) begin
            s = '{"stream", 0, 24'h800000 | 24'(i), 0, 8'h7F, 0, 0, 32'h0, 32'h3F800000 | 32'(i), 0, 0};
            drive(s);
            @(posedge Clk); #1;
            check_out(s);
        end
        InValid = 1'b0;
        @(posedge Clk); #1;
        check("stream end valid", {31'b0, OutValid}, 32'd0);

`ifdef STICKY_FLAGS_EN
        check("sticky init", {31'b0, StickyOverflow}, 32'd0);
        drive(vecs[2]);
        @(posedge Clk); #1;
        InValid = 1'b0;
        check("sticky pre", {31'b0, StickyOverflow}, 32'd0);
        @(posedge Clk); #1;
        check("sticky set", {31'b0, StickyOverflow}, 32'd1);
        @(posedge Clk); #1;
        check("sticky hold", {31'b0, StickyOverflow}, 32'd1);
        FlagClear = 1'b1;
        @(posedge Clk); #1;
        FlagClear = 1'b0;
        check("sticky clear", {31'b0, StickyOverflow}, 32'd0);
`endif

        // Asynchronous reset while holding an overflow result
        OutReady = 1'b0;
        drive(vecs[2]);
        @(posedge Clk); #1;
        InValid = 1'b0;
        check_out(vecs[2]);
        #2;
        ResetN = 1'b0;
        #1;
        check("arst valid",    {31'b0, OutValid}, 32'd0);
        check("arst result",   Result, 32'd0);
        check("arst overflow", {31'b0, Overflow}, 32'd0);
        check("arst zero",     {31'b0, Zero}, 32'd0);
        @(negedge Clk);
        ResetN = 1'b1;
        OutReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            check("post rst valid", {31'b0, OutValid}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
